// File: rtl/main_control_fsm.sv
`default_nettype none
// main_control_fsm: multicycle MIPS-subset controller with retired-instruction
// counter and illegal-opcode flag. Rev 1.0
module main_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Op,
  input  logic        MemRdy,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCEn,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALUOp,
  output logic [3:0]  State,
  output logic        IllegalOp,
  output logic [15:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;

  state_t        r_state;
  state_t        w_next;
  ctl_t          r_ctl;
  logic          r_illegal;
  logic [15:0]   r_instr_count;
  logic          w_retire;
  logic          w_illegal;
  logic          w_fetch_rdy;

  // Moore control word for a state; registered against the next state so the
  // outputs line up with State in the same cycle.
  function automatic ctl_t f_decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = ALU_ADD; end
      S_DECODE: begin c.alu_src_b = 2'b11; c.alu_op = ALU_ADD; end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = ALU_ADD;
      end
      S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = ALU_RTYPE; end
      S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = MemRdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = MemRdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = MemRdy ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Only completed instructions retire; the DECODE bail-out is excluded.
  assign w_retire  = (r_state inside {S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB}) ||
                     ((r_state == S_MEMWR) && MemRdy);
  assign w_illegal = (r_state == S_DECODE) && (w_next == S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_ctl         <= f_decode(S_FETCH);
      r_illegal     <= 1'b0;
      r_instr_count <= 16'd0;
    end else begin
      r_state   <= w_next;
      r_ctl     <= f_decode(w_next);
      r_illegal <= w_illegal;
      if (w_retire)
        r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign w_fetch_rdy = (r_state == S_FETCH) && MemRdy;

  assign PCWrite     = r_ctl.pc_write | w_fetch_rdy;
  assign IRWrite     = w_fetch_rdy;
  assign PCWriteCond = r_ctl.pc_write_cond;
  assign PCEn        = PCWrite | (PCWriteCond & Zero);
  assign IorD        = r_ctl.iord;
  assign MemRead     = r_ctl.mem_read;
  assign MemWrite    = r_ctl.mem_write;
  assign MemtoReg    = r_ctl.mem_to_reg;
  assign RegDst      = r_ctl.reg_dst;
  assign RegWrite    = r_ctl.reg_write;
  assign ALUSrcA     = r_ctl.alu_src_a;
  assign ALUSrcB     = r_ctl.alu_src_b;
  assign PCSource    = r_ctl.pc_source;
  assign ALUOp       = r_ctl.alu_op;
  assign State       = r_state;
  assign IllegalOp   = r_illegal;
  assign InstrCount  = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// tb_main_control_fsm: directed vectors with hand-computed expectations. Rev 1.0
module tb_main_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [5:0]  Op;
  logic        MemRdy;
  logic        Zero;
  logic        PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite;
  logic        MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [3:0]  State;
  logic        IllegalOp;
  logic [15:0] InstrCount;

  int n_checks;
  int n_fail;

  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .MemRdy(MemRdy), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .State(State), .IllegalOp(IllegalOp),
    .InstrCount(InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One active edge, then sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    Op       = 6'b000000;
    MemRdy   = 1'b0;
    Zero     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_state", State, 0);
    check("rst_count", InstrCount, 0);
    check("rst_illegal", IllegalOp, 0);
    check("rst_memread", MemRead, 1);
    check("rst_alusrcb", ALUSrcB, 2'b01);
    check("rst_aluop", ALUOp, 3'b001);
    check("rst_pcwrite_nordy", PCWrite, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("fetch_hold", State, 0);

    // R-type
    MemRdy = 1'b1; Op = 6'b000000;
    #1;
    check("r_fetch_pcwrite", PCWrite, 1);
    check("r_fetch_irwrite", IRWrite, 1);
    step(); check("r_decode", State, 1); check("r_dec_aluop", ALUOp, 3'b001);
    check("r_dec_alusrcb", ALUSrcB, 2'b11);
    step(); check("r_exec", State, 6); check("r_exec_aluop", ALUOp, 3'b000);
    check("r_exec_alusrca", ALUSrcA, 1);
    step(); check("r_aluwb", State, 7); check("r_regwrite", RegWrite, 1);
    check("r_regdst", RegDst, 1);
    step(); check("r_back_fetch", State, 0); check("r_count", InstrCount, 1);

    // lw with a 3-cycle memory stall
    Op = 6'b100011;
    step(); check("lw_decode", State, 1);
    step(); check("lw_memadr", State, 2); check("lw_alusrcb", ALUSrcB, 2'b10);
    MemRdy = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("lw_memrd_hold", State, 3);
      check("lw_memread", MemRead, 1);
      check("lw_iord", IorD, 1);
      if (i == 3) MemRdy = 1'b1;
      step();
    end
    check("lw_memwb", State, 4); check("lw_memtoreg", MemtoReg, 1);
    check("lw_regwrite", RegWrite, 1);
    step(); check("lw_count", InstrCount, 2);

    // beq taken then not taken
    Op = 6'b000100; Zero = 1'b1;
    step(); step();
    check("beq1_state", State, 8); check("beq1_aluop", ALUOp, 3'b010);
    check("beq1_pcen", PCEn, 1); check("beq1_pcsrc", PCSource, 2'b01);
    check("beq1_pcwc", PCWriteCond, 1);
    step(); Zero = 1'b0;
    step(); step();
    check("beq2_state", State, 8); check("beq2_pcen", PCEn, 0);
    step(); check("beq_count", InstrCount, 4);

    // illegal opcode
    Op = 6'b111111;
    step(); check("ill_decode", State, 1);
    step(); check("ill_fetch", State, 0); check("ill_flag", IllegalOp, 1);
    check("ill_count", InstrCount, 4);
    MemRdy = 1'b0;
    step(); check("ill_flag_clear", IllegalOp, 0);

    // sw stalled in MEMWR, then asynchronous reset
    MemRdy = 1'b1; Op = 6'b101011;
    step(); step(); check("sw_memadr", State, 2);
    MemRdy = 1'b0;
    step(); check("sw_memwr", State, 5); check("sw_memwrite", MemWrite, 1);
    check("sw_iord", IorD, 1);
    step(); check("sw_hold", State, 5); check("sw_count_pending", InstrCount, 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", State, 0); check("arst_memwrite", MemWrite, 0);
    check("arst_count", InstrCount, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // counter wrap on j
    dut.r_instr_count = 16'hFFFF;
    MemRdy = 1'b1; Op = 6'b000010;
    #1 check("preload", InstrCount, 16'hFFFF);
    step(); check("j_decode", State, 1);
    step(); check("j_state", State, 9); check("j_pcwrite", PCWrite, 1);
    check("j_pcsrc", PCSource, 2'b10); check("j_pcen", PCEn, 1);
    step(); check("j_wrap", InstrCount, 0); check("j_fetch", State, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
